// File: rtl/counter_load_scheduler.sv
// counter_load_scheduler
// Shares one loadable up-counter between two requesters. A round-robin
// arbiter picks an owner in IDLE, the owner's start value is captured and
// loaded into the counter (LOAD). The job then runs until the counter
// reaches TERM (RUN), and a one-cycle done pulse is produced (DONE). If the
// owner withdraws during RUN, the job ends with an abort pulse instead.
module counter_load_scheduler #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TERM  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] cnt_dout,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_din,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             abort,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic             owner, owner_nx;   // 0: requester 0, 1: requester 1
    logic             last, last_nx;     // last-served requester
    logic [WIDTH-1:0] cap, cap_nx;       // start value captured at grant
    logic             owner_req;
    logic             pick;

    // State register plus the owner, pointer and captured start value.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;   // requester 0 wins the first tie
            cap   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            cap   <= cap_nx;
        end
    end

    assign owner_req = owner ? req1 : req0;

    // Next-state logic, arbitration and the per-state strobes.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        cap_nx   = cap;
        pick     = 1'b0;
        cnt_load = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        abort    = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that was not served last wins.
                    pick     = (req0 && req1) ? ~last : req1;
                    owner_nx = pick;
                    cap_nx   = pick ? din1 : din0;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                // Requests are not checked here; a drop only counts in RUN.
                cnt_load = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                if (!owner_req) begin
                    abort    = 1'b1;
                    last_nx  = owner;
                    state_nx = IDLE;
                end else if (cnt_dout == TERM) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done0    = ~owner;
                done1    = owner;
                last_nx  = owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign gnt0    = busy && !owner;
    assign gnt1    = busy && owner;
    assign cnt_din = cap;

endmodule

// File: tb/tb_counter_load_scheduler.sv
// tb_counter_load_scheduler
// Drives the scheduler with a behavioural loadable 4-bit counter attached.
// Expected behaviour is generated per job as a cycle trace: one arbitration
// cycle, one LOAD cycle, (16 - v) RUN cycles, then DONE, or an early abort.
module tb_counter_load_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_b = 2'b00;
    logic [3:0] din_b [2];
    logic [3:0] cnt = 4'd0;
    logic       cnt_load;
    logic [3:0] cnt_din;
    logic       gnt0, gnt1, done0, done1, abort, busy;

    int total = 0;
    int bad   = 0;

    // Reference state kept at job level.
    logic       model_last = 1'b1;
    logic [3:0] model_cap  = 4'd0;

    counter_load_scheduler #(.WIDTH(4), .TERM(4'hF)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req_b[0]),
        .req1     (req_b[1]),
        .din0     (din_b[0]),
        .din1     (din_b[1]),
        .cnt_dout (cnt),
        .cnt_load (cnt_load),
        .cnt_din  (cnt_din),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .abort    (abort),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Attached counter: load on strobe, otherwise increment every edge.
    always @(posedge clk) cnt <= cnt_load ? cnt_din : cnt + 4'd1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] flags();
        return {busy, gnt1, gnt0, cnt_load, done1, done0, abort};
    endfunction

    // Requests low; every cycle must look idle with cnt_din holding the capture.
    task automatic idle_cycles(input int n);
        logic [6:0] obs;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_b = 2'b00;
            #1;
            obs = flags();
            total++;
            if (obs !== 7'b0) begin
                bad++;
                $display("FAIL idle_flags: got %b expected %b", obs, 7'b0);
            end
            total++;
            if (cnt_din !== model_cap) begin
                bad++;
                $display("FAIL idle_din: got %0h expected %0h", cnt_din, model_cap);
            end
        end
    endtask

    // One complete job starting from IDLE. drop_at: 0 = never, k = owner drops
    // req in RUN cycle k, negative = random choice. load_din is written to the
    // winner's din during LOAD; ld_drop drops the winner's req during LOAD only.
    task automatic run_job(input logic r0, input logic r1,
                           input logic [3:0] d0, input logic [3:0] d1,
                           input int drop_at, input logic [3:0] load_din,
                           input logic ld_drop);
        logic       w;
        logic [3:0] v;
        int         n;
        int         drop;
        logic [6:0] obs, exp;

        // Arbitration cycle (IDLE)
        @(negedge clk);
        req_b    = {r1, r0};
        din_b[0] = d0;
        din_b[1] = d1;
        #1;
        obs = flags();
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL arb_flags: got %b expected %b", obs, 7'b0);
        end

        w = (r0 && r1) ? ~model_last : r1;
        v = w ? d1 : d0;
        n = 16 - int'(v);
        model_cap = v;
        drop = drop_at;
        if (drop_at < 0) drop = (n >= 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n - 1)) : 0;

        // LOAD cycle
        @(negedge clk);
        din_b[w] = load_din;
        if (ld_drop) req_b[w] = 1'b0;
        #1;
        obs = flags();
        exp = {1'b1, w, ~w, 1'b1, 3'b000};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL load_flags: got %b expected %b (owner %0d)", obs, exp, w);
        end
        total++;
        if (cnt_din !== v) begin
            bad++;
            $display("FAIL load_din: got %0h expected %0h", cnt_din, v);
        end

        // RUN cycles
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            req_b[w] = (k == drop) ? 1'b0 : 1'b1;
            #1;
            obs = flags();
            exp = {1'b1, w, ~w, 1'b0, 2'b00, (k == drop)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL run_flags: got %b expected %b (run cycle %0d of %0d)", obs, exp, k, n);
            end
            total++;
            if (cnt_din !== v) begin
                bad++;
                $display("FAIL run_din: got %0h expected %0h", cnt_din, v);
            end
            if (k == drop) begin
                model_last = w;
                return;
            end
        end

        // DONE cycle
        @(negedge clk);
        #1;
        obs = flags();
        exp = {1'b1, w, ~w, 1'b0, w, ~w, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL done_flags: got %b expected %b (owner %0d)", obs, exp, w);
        end
        model_last = w;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1;
        req_b = 2'b00;
        din_b[0] = 4'd0;
        din_b[1] = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        obs = flags();
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b expected %b", obs, 7'b0);
        end
        total++;
        if (cnt_din !== 4'd0) begin
            bad++;
            $display("FAIL reset_din: got %0h expected 0", cnt_din);
        end
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        model_cap  = 4'd0;
        idle_cycles(2);
    endtask

    task automatic test_single_job();
        run_job(1'b1, 1'b0, 4'd3, 4'd0, 0, 4'd3, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_round_robin();
        run_job(1'b1, 1'b1, 4'd13, 4'd14, 0, 4'd13, 1'b0);
        run_job(1'b1, 1'b1, 4'd13, 4'd14, 0, 4'd14, 1'b0);
        run_job(1'b1, 1'b1, 4'd13, 4'd14, 0, 4'd13, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_term_start();
        run_job(1'b0, 1'b1, 4'd0, 4'hF, 0, 4'hF, 1'b0);
        idle_cycles(1);
    endtask

    task automatic test_abort();
        run_job(1'b0, 1'b1, 4'd0, 4'd5, 5, 4'd5, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_din_change();
        run_job(1'b1, 1'b0, 4'd3, 4'd0, 0, 4'd9, 1'b0);
        idle_cycles(1);
        run_job(1'b1, 1'b0, 4'd12, 4'd0, 0, 4'd12, 1'b1);
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_job();
        logic [6:0] obs;
        @(negedge clk);
        req_b    = 2'b01;
        din_b[0] = 4'd2;
        repeat (3) @(negedge clk);   // LOAD, then two RUN cycles
        rst = 1'b1;
        #1;
        obs = flags();
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL midjob_reset_flags: got %b expected %b", obs, 7'b0);
        end
        total++;
        if (cnt_din !== 4'd0) begin
            bad++;
            $display("FAIL midjob_reset_din: got %0h expected 0", cnt_din);
        end
        req_b = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        model_cap  = 4'd0;
        idle_cycles(3);
    endtask

    task automatic test_random();
        logic [1:0] r;
        logic [3:0] d0, d1, ld;
        for (int i = 0; i < 30; i++) begin
            r  = 2'($urandom_range(0, 3));
            d0 = 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
            ld = 4'($urandom_range(0, 15));
            if (r == 2'b00) begin
                idle_cycles(1);
            end else begin
                run_job(r[0], r[1], d0, d1, -1, ld, ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 1) == 0) idle_cycles(1);
            end
        end
    endtask

    initial begin
        din_b[0] = 4'd0;
        din_b[1] = 4'd0;
        test_reset();
        test_single_job();
        test_round_robin();
        test_term_start();
        test_abort();
        test_din_change();
        test_reset_mid_job();
        test_round_robin();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_load_scheduler.md
COUNTER_LOAD_SCHEDULER -- requirements
Module: counter_load_scheduler

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, which sets the counter data width.
REQ-002 The module SHALL have parameter TERM, default {WIDTH{1'b1}}, which is the terminal count that ends a job.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req0, req1  input  1 each  requester asks for use of the shared counter; held high until done or abort.
REQ-006 Port din0, din1  input  WIDTH each  start value of requester 0 and requester 1.
REQ-007 Port cnt_dout  input  WIDTH  current value of the attached loadable up-counter.
REQ-008 Port cnt_load  output  1  load strobe to the counter.
REQ-009 Port cnt_din  output  WIDTH  load value to the counter.
REQ-010 Port gnt0, gnt1  output  1 each  requester currently owns the counter.
REQ-011 Port done0, done1  output  1 each  one-cycle pulse when the owner's job reaches TERM.
REQ-012 Port abort  output  1  one-cycle pulse when the owner withdraws mid-job.
REQ-013 Port busy  output  1  high whenever state != IDLE.

Function
REQ-014 The attached counter loads cnt_din on an edge with cnt_load=1 and otherwise increments by 1 (mod 2^WIDTH) every edge; the scheduler SHALL rely on exactly this behaviour.
REQ-015 The FSM SHALL have the states IDLE, LOAD, RUN and DONE, with one state register.
REQ-016 In IDLE, if either req is high, the FSM SHALL select one owner, capture that owner's din into a WIDTH-bit register, and go to LOAD on the next edge; if neither req is high, it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin with a one-bit last-served pointer: if both req are high, the requester that is not last-served wins; if only one req is high, that requester wins regardless of the pointer.
REQ-018 gnt of the owner SHALL be high in LOAD, RUN and DONE, and both gnt SHALL be low in IDLE; at most one gnt is high at any time.
REQ-019 In LOAD, cnt_load SHALL be 1 and cnt_din SHALL equal the captured value; the next state SHALL be RUN.
REQ-020 In every state other than LOAD, cnt_load SHALL be 0 and cnt_din SHALL hold the captured value.
REQ-021 In RUN, if cnt_dout == TERM, the FSM SHALL go to DONE; otherwise it SHALL stay in RUN. A job therefore spends TERM - v + 1 cycles in RUN for start value v.
REQ-022 In DONE, the owner's done output SHALL be 1 for exactly one cycle, the last-served pointer SHALL update to the owner, and the next state SHALL be IDLE.
REQ-023 If the owner's req is low during RUN, the FSM SHALL go to IDLE at the next edge and pulse abort for that cycle, with no done pulse; the pointer SHALL still update to the owner.
REQ-024 A req drop during LOAD SHALL be ignored; the abort check applies only in RUN.
REQ-025 Changes on din0/din1 after capture SHALL NOT affect cnt_din until the next grant.
REQ-026 A start value equal to TERM SHALL yield exactly one RUN cycle, then DONE.
REQ-027 An owner still requesting after DONE SHALL re-arbitrate in IDLE, so the other requester wins if it is also requesting.
REQ-028 There SHALL be one IDLE cycle between consecutive jobs, giving a minimum period of 3 + RUN cycles.

Reset
REQ-029 While rst=1, the outputs SHALL be: state=IDLE, pointer=1 (so requester 0 wins the first tie), captured value=0, and cnt_load, gnt0, gnt1, done0, done1, abort and busy all 0; cnt_din SHALL be 0.
REQ-030 Reset SHALL take effect immediately, including mid-job, without waiting for a clock edge; no done or abort pulse SHALL be produced for a job killed by reset.

Verification
REQ-031 The bench SHALL drive rst=1 during RUN -> gnt0/gnt1, busy and cnt_load go to 0 before the next edge; after release with no req, the FSM stays in IDLE.
REQ-032 The bench SHALL drive req0=1, din0=3 with a behavioural 4-bit counter attached -> cnt_load high for 1 cycle with cnt_din=3, 13 RUN cycles, then done0 pulses once; gnt0 is high from LOAD through DONE.
REQ-033 The bench SHALL raise req0 and req1 together after reset -> gnt0 is granted first; with both held, gnt1 is granted after one IDLE cycle, and then gnt0 again.
REQ-034 The bench SHALL drive req1=1, din1=4'hF -> one RUN cycle, then done1.
REQ-035 The bench SHALL drive req1 low for the 5th RUN cycle of a job -> abort pulses, gnt1 falls at the next edge, and done1 never asserts.
REQ-036 The bench SHALL change din0 from 3 to 9 during LOAD -> cnt_din stays 3 and the job length is unchanged.
